// File: rtl/camara_pkg.sv
// Shared types and constants for the camera processing sequencer.
// State encoding, color/figure codes and the default timeout.
package camara_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_COLLECT   = 3'd3,
        S_REPORT    = 3'd4
    } state_e;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_R    = 2'd1;
    localparam logic [1:0] C_G    = 2'd2;
    localparam logic [1:0] C_B    = 2'd3;

    localparam logic [1:0] F_NONE = 2'd0;
    localparam logic [1:0] F_TRI  = 2'd1;
    localparam logic [1:0] F_CIR  = 2'd2;
    localparam logic [1:0] F_SQR  = 2'd3;

    // 100 ms at 100 MHz
    localparam int unsigned TIMEOUT_DEF = 10_000_000;

endpackage

// File: rtl/vote4.sv
// Four 3-bit class counters with clear, increment-by-code and a
// tie-aware argmax (a shared maximum reports code 0).
module vote4
    import camara_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       inc_i,
    input  logic [1:0] code_i,
    output logic [1:0] win_o
);

    logic [3:0][2:0] cnt_q;
    logic [3:0][2:0] cnt_d;
    logic [2:0]      best;
    logic [1:0]      idx;
    logic            tie;

    // next-state of the class counters, saturating at 7
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (clr_i) begin
                cnt_d[i] = 3'd0;
            end else if (inc_i && code_i == 2'(i) && cnt_q[i] != 3'd7) begin
                cnt_d[i] = cnt_q[i] + 3'd1;
            end
        end
    end

    // counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // argmax with tie detection
    always_comb begin
        best = cnt_q[0];
        idx  = C_NONE;
        tie  = 1'b0;
        for (int i = 1; i < 4; i++) begin
            if (cnt_q[i] > best) begin
                best = cnt_q[i];
                idx  = 2'(i);
                tie  = 1'b0;
            end else if (cnt_q[i] == best) begin
                tie = 1'b1;
            end
        end
        win_o = tie ? C_NONE : idx;
    end

endmodule

// File: rtl/procesamiento_ctrl.sv
// Sequencer arming the procesamiento block on frame boundaries and
// publishing one validated color/figure result. Macro: PROC_CTRL_VOTE_EN.
module procesamiento_ctrl
    import camara_pkg::*;
#(
    parameter int unsigned FRAMES  = 3,
    parameter int unsigned TO_W    = 24,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    input  logic       abort,
    input  logic       frame_start,
    input  logic       proc_done,
    input  logic [1:0] proc_color,
    input  logic [1:0] proc_figure,
    output logic       init_procesamiento,
    output logic       busy,
    output logic       result_valid,
    output logic [1:0] color,
    output logic [1:0] figure,
    output logic       err_timeout,
    output logic [2:0] frame_cnt
);

`ifdef PROC_CTRL_VOTE_EN
    localparam logic [2:0] N_FR = 3'(FRAMES);
`else
    localparam logic [2:0] N_FR = 3'd1;
`endif
    localparam logic [TO_W:0] TO_LIM = (TO_W+1)'(TIMEOUT);

    state_e          state_q, state_d;
    logic            done_s_q, done_e_q;
    logic [TO_W-1:0] to_q, to_d, to_sat;
    logic [TO_W:0]   to_inc;
    logic [2:0]      fcnt_q, fcnt_d, fcnt_inc;
    logic            err_q, err_d;
    logic            rv_q, rv_d;
    logic [1:0]      color_q, color_d;
    logic [1:0]      figure_q, figure_d;
    logic            clr, inc;
    logic [1:0]      res_c, res_f;
    logic            done_rise, expired;

    assign done_rise = done_s_q & ~done_e_q;
    // elapsed cycles since arming, counting the current one
    assign to_inc    = {1'b0, to_q} + (TO_W+1)'(1);
    assign expired   = to_inc >= TO_LIM;
    assign to_sat    = (to_q == '1) ? to_q : to_inc[TO_W-1:0];
    assign fcnt_inc  = fcnt_q + 3'd1;

`ifdef PROC_CTRL_VOTE_EN
    vote4 u_vote_c (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .inc_i  (inc),
        .code_i (proc_color),
        .win_o  (res_c)
    );

    vote4 u_vote_f (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .inc_i  (inc),
        .code_i (proc_figure),
        .win_o  (res_f)
    );
`else
    logic [1:0] samp_c_q, samp_f_q;

    // single-frame sample handed straight to REPORT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_c_q <= C_NONE;
            samp_f_q <= F_NONE;
        end else if (clr) begin
            samp_c_q <= C_NONE;
            samp_f_q <= F_NONE;
        end else if (inc) begin
            samp_c_q <= proc_color;
            samp_f_q <= proc_figure;
        end
    end

    assign res_c = samp_c_q;
    assign res_f = samp_f_q;
`endif

    // done synchroniser and edge register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_s_q <= 1'b0;
            done_e_q <= 1'b0;
        end else begin
            done_s_q <= proc_done;
            done_e_q <= done_s_q;
        end
    end

    // sequencer next-state and datapath control
    always_comb begin
        state_d  = state_q;
        to_d     = to_q;
        fcnt_d   = fcnt_q;
        err_d    = err_q;
        rv_d     = 1'b0;
        color_d  = color_q;
        figure_d = figure_q;
        clr      = 1'b0;
        inc      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    fcnt_d  = 3'd0;
                    err_d   = 1'b0;
                    to_d    = '0;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                to_d = to_sat;
                if (frame_start) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                to_d = to_sat;
                if (done_rise) begin
                    state_d = S_COLLECT;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                inc    = 1'b1;
                fcnt_d = fcnt_inc;
                to_d   = '0;
                if (fcnt_inc >= N_FR) begin
                    state_d = S_REPORT;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_REPORT: begin
                rv_d     = 1'b1;
                color_d  = res_c;
                figure_d = res_f;
                if (continuous) begin
                    clr     = 1'b1;
                    fcnt_d  = 3'd0;
                    to_d    = '0;
                    state_d = S_ARM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // abort freezes every published value and wins over start
        if (abort) begin
            state_d  = S_IDLE;
            fcnt_d   = fcnt_q;
            err_d    = err_q;
            rv_d     = 1'b0;
            color_d  = color_q;
            figure_d = figure_q;
            clr      = 1'b0;
            inc      = 1'b0;
        end
    end

    // sequencer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            to_q     <= '0;
            fcnt_q   <= 3'd0;
            err_q    <= 1'b0;
            rv_q     <= 1'b0;
            color_q  <= C_NONE;
            figure_q <= F_NONE;
        end else begin
            state_q  <= state_d;
            to_q     <= to_d;
            fcnt_q   <= fcnt_d;
            err_q    <= err_d;
            rv_q     <= rv_d;
            color_q  <= color_d;
            figure_q <= figure_d;
        end
    end

    assign init_procesamiento = (state_q == S_ARM);
    assign busy               = (state_q != S_IDLE);
    assign result_valid       = rv_q;
    assign color              = color_q;
    assign figure             = figure_q;
    assign err_timeout        = err_q;
    assign frame_cnt          = fcnt_q;

endmodule

// File: tb/tb_procesamiento_ctrl.sv
// Directed bench for procesamiento_ctrl: reset, single/voted results,
// tie, timeout, continuous mode with abort, reset mid-measurement.
module tb_procesamiento_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, continuous, abort, frame_start, proc_done;
    logic [1:0] proc_color, proc_figure;
    logic       init_procesamiento, busy, result_valid, err_timeout;
    logic [1:0] color, figure;
    logic [2:0] frame_cnt;

    int checks = 0;
    int errors = 0;

`ifdef PROC_CTRL_VOTE_EN
    localparam int FR = 3;
    logic [1:0] ec [3] = '{2'd1, 2'd3, 2'd0};
    logic [1:0] ef [3] = '{2'd2, 2'd1, 2'd2};
`else
    localparam int FR = 1;
    logic [1:0] ec [3] = '{2'd1, 2'd3, 2'd1};
    logic [1:0] ef [3] = '{2'd2, 2'd1, 2'd2};
`endif
    logic [1:0] tc [3][3] = '{'{2'd1, 2'd1, 2'd1},
                              '{2'd3, 2'd2, 2'd3},
                              '{2'd1, 2'd2, 2'd3}};
    logic [1:0] tf [3][3] = '{'{2'd2, 2'd2, 2'd2},
                              '{2'd1, 2'd1, 2'd3},
                              '{2'd2, 2'd2, 2'd1}};

    int         rv_cnt     = 0;
    int         init_rises = 0;
    logic [1:0] last_c     = 2'd0;
    logic [1:0] last_f     = 2'd0;
    logic       init_prev  = 1'b0;

    always #5 clk = ~clk;

    procesamiento_ctrl #(
        .FRAMES  (3),
        .TO_W    (24),
        .TIMEOUT (100)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .continuous         (continuous),
        .abort              (abort),
        .frame_start        (frame_start),
        .proc_done          (proc_done),
        .proc_color         (proc_color),
        .proc_figure        (proc_figure),
        .init_procesamiento (init_procesamiento),
        .busy               (busy),
        .result_valid       (result_valid),
        .color              (color),
        .figure             (figure),
        .err_timeout        (err_timeout),
        .frame_cnt          (frame_cnt)
    );

    // result pulse and arm-edge monitor
    always @(negedge clk) begin
        if (result_valid) begin
            rv_cnt <= rv_cnt + 1;
            last_c <= color;
            last_f <= figure;
        end
        if (init_procesamiento && !init_prev) begin
            init_rises <= init_rises + 1;
        end
        init_prev <= init_procesamiento;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!init_procesamiento && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(init_procesamiento), 32'd1);
    endtask

    task automatic do_frame(input logic [1:0] c, input logic [1:0] f);
        wait_init("arm_wait");
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("init_drop", 32'(init_procesamiento), 32'd0);
        proc_color  = c;
        proc_figure = f;
        proc_done   = 1'b1;
        repeat (4) @(negedge clk);
        proc_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic measure(input int t);
        int rv0;
        int ir0;
        rv0 = rv_cnt;
        ir0 = init_rises;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("fcnt_clr", 32'(frame_cnt), 32'd0);
        for (int i = 0; i < FR; i++) begin
            do_frame(tc[t][i], tf[t][i]);
        end
        repeat (2) @(negedge clk);
        chk("rv_pulses", 32'(rv_cnt - rv0), 32'd1);
        chk("color", 32'(last_c), 32'(ec[t]));
        chk("figure", 32'(last_f), 32'(ef[t]));
        chk("fcnt_end", 32'(frame_cnt), 32'(FR));
        chk("arm_count", 32'(init_rises - ir0), 32'(FR));
        chk("busy_end", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv0;
        rst         = 1'b0;
        start       = 1'b0;
        continuous  = 1'b0;
        abort       = 1'b0;
        frame_start = 1'b0;
        proc_done   = 1'b0;
        proc_color  = 2'd0;
        proc_figure = 2'd0;
        #12;
        chk("rst_init", 32'(init_procesamiento), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_color", 32'(color), 32'd0);
        chk("rst_figure", 32'(figure), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // uniform, voted and tied measurements
        measure(0);
        measure(1);
        measure(2);

        // timeout with done stuck high
        rv0       = rv_cnt;
        proc_done = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start       = 1'b0;
        frame_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_start = 1'b0;
        repeat (98) @(posedge clk);
        #1;
        chk("to_early_err", 32'(err_timeout), 32'd0);
        chk("to_early_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("to_err", 32'(err_timeout), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_init", 32'(init_procesamiento), 32'd0);
        @(negedge clk);
        proc_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("to_sticky", 32'(err_timeout), 32'd1);
        chk("to_no_rv", 32'(rv_cnt - rv0), 32'd0);

        // continuous: two results, then abort with start
        rv0        = rv_cnt;
        continuous = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_cleared", 32'(err_timeout), 32'd0);
        for (int i = 0; i < FR; i++) do_frame(tc[0][i], tf[0][i]);
        chk("cont_first_c", 32'(last_c), 32'(ec[0]));
        for (int i = 0; i < FR; i++) do_frame(tc[1][i], tf[1][i]);
        chk("cont_rv", 32'(rv_cnt - rv0), 32'd2);
        chk("cont_c", 32'(last_c), 32'(ec[1]));
        chk("cont_f", 32'(last_f), 32'(ef[1]));
        wait_init("cont_rearm");
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_init", 32'(init_procesamiento), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("abort_start_ign", 32'(busy), 32'd0);
        chk("abort_hold_c", 32'(color), 32'(ec[1]));
        chk("abort_hold_f", 32'(figure), 32'(ef[1]));
        continuous = 1'b0;

        // asynchronous reset while armed
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_init("pre_rst_arm");
        #3;
        rst = 1'b0;
        #1;
        chk("arst_init", 32'(init_procesamiento), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_color", 32'(color), 32'd0);
        chk("arst_figure", 32'(figure), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_init", 32'(init_procesamiento), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
